conversor_adc: RTL
==================

Name: conversor_ADC

Overview:
- SPI reader for the on-board dual-channel 14-bit ADC. It is the capture-side counterpart of the DAC transmitter on the same shared SPI bus.
- On request it pulses ad_conv, clocks 34 SCK cycles and shifts two two's-complement samples in from spi_miso, MSB first.
- It then presents both samples with a one-cycle valid strobe.
- It sits between the SPI pins and the processing/DAC path. The top level arbitrates the bus using the ocupado output.

Parameters:
- CLK_DIV, 2, SCK half-period in clock cycles (>=1). SCK frequency = clock/(2*CLK_DIV).

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clock_enable  in  1  start request, sampled only in IDLE.
- spi_miso  in  1  serial data from the ADC.
- spi_sck  out  1  SPI clock, registered (not gated).
- ad_conv  out  1  conversion-start pulse to the ADC.
- canal_a  out  14  channel A sample, two's complement.
- canal_b  out  14  channel B sample, two's complement.
- muestra_dac  out  12  canal_a[13:2], ready for the DAC path.
- dato_valido  out  1  one-cycle strobe: canal_a/canal_b updated.
- ocupado  out  1  high from request acceptance through DONE.

Behaviour:
- Reset (synchronous, takes effect at the next edge, also mid-frame):
  - state=IDLE; spi_sck=0, ad_conv=0, dato_valido=0, ocupado=0.
  - canal_a=0, canal_b=0; shift register, bit counter and divider cleared.
  - The aborted frame produces no dato_valido.
- The divider counts 0..CLK_DIV-1 and produces a tick at terminal count. It runs only in CONV and SHIFT.
- IDLE:
  - spi_sck=0, ad_conv=0.
  - clock_enable=1 moves to CONV; ocupado=1 from the next cycle.
- CONV:
  - ad_conv=1, spi_sck=0 for exactly 2*CLK_DIV clocks (one SCK period), then SHIFT.
- SHIFT: 34 SCK periods, bit index k=0..33.
  - Each period is spi_sck=0 for CLK_DIV clocks, then spi_sck=1 for CLK_DIV clocks.
  - spi_miso is sampled on the clock in which spi_sck is driven 0->1.
  - Bits k=2..15 go to canal_a, bit 13 first.
  - Bits k=18..31 go to canal_b, bit 13 first.
  - Bits k=0,1,16,17,32,33 are discarded.
  - After the high half of k=33: spi_sck=0, move to DONE.
- DONE (1 clock):
  - canal_a/canal_b load from the shift register; dato_valido=1.
  - ocupado=0 next cycle, then IDLE.
- canal_a/canal_b hold their previous value at all other times.
- muestra_dac is combinational from canal_a.
- Latency: request sampled at cycle t, dato_valido at t+1+70*CLK_DIV (t+141 for CLK_DIV=2).
- clock_enable in CONV, SHIFT or DONE is ignored (not queued).
- clock_enable held high gives back-to-back frames with one IDLE clock between them. Period is 2+70*CLK_DIV clocks (142 for the default).
- Total rising SCK edges per frame: exactly 34. spi_sck never toggles outside SHIFT.

Decomposition:
- Shared package:
  - FRAME_BITS=34, DATA_BITS=14.
  - CH_A_FIRST=2, CH_B_FIRST=18.
  - DAC_BITS=12.
  - state encoding IDLE/CONV/SHIFT/DONE.
  - The DAC transmitter reuses DAC_BITS.
- One sub-module, generador_sck: the CLK_DIV counter plus the registered SCK phase. It outputs a rise tick and a period-end tick, with a run enable.

Test Plan:
- Reset asserted 3 clocks with spi_miso=1 -> all outputs 0 and no SCK edges; after release, outputs stay idle with clock_enable=0.
- ADC model returns A=14'h2ABC, B=14'h1555, dummy bits=1, with a clock_enable pulse at t and CLK_DIV=2:
  - ad_conv high at t+1..t+4.
  - exactly 34 SCK rising edges.
  - dato_valido only at t+141.
  - canal_a=14'h2ABC, canal_b=14'h1555, muestra_dac=12'hAAF.
- Model returns A=14'h2000, B=14'h1FFF -> canal_a=14'h2000, muestra_dac=12'h800, canal_b=14'h1FFF.
- Extra clock_enable pulses at t+10 and t+100 during a frame -> exactly one dato_valido and ocupado continuous; the next request after ocupado falls is accepted.
- reset at t+60 mid-SHIFT:
  - next clock spi_sck=0, ad_conv=0, ocupado=0, canal_a=canal_b=0.
  - no dato_valido.
  - a following request completes normally with the correct data.
- clock_enable tied high:
  - CLK_DIV=2 -> dato_valido every 142 clocks.
  - rerun with CLK_DIV=1 -> first strobe at t+71, period 72, data correct.

Source files
------------

// File: rtl/conversor_adc_pkg.sv
// rtl/conversor_adc_pkg.sv - shared frame constants and FSM encoding for the ADC SPI reader
package conversor_adc_pkg;

    localparam int FRAME_BITS = 34;
    localparam int DATA_BITS  = 14;
    localparam int CH_A_FIRST = 2;
    localparam int CH_B_FIRST = 18;
    localparam int DAC_BITS   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

endpackage

// File: rtl/conversor_adc_generador_sck.sv
// rtl/conversor_adc_generador_sck.sv - CLK_DIV divider with registered SCK phase and rise/period ticks
module generador_sck #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic sck_en,
    output logic sck,
    output logic rise_tick,
    output logic period_end
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             sck_q, sck_d;
    logic             term;

    always_comb begin
        term       = (cnt_q == CNT_W'(CLK_DIV - 1));
        rise_tick  = run && term && !phase_q;
        period_end = run && term && phase_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (term) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // The phase also runs during CONV; only SHIFT lets it reach the pin.
        sck_d = sck_en && phase_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            sck_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sck_q   <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/conversor_adc.sv
// rtl/conversor_adc.sv - SPI reader for the dual-channel 14-bit ADC
module conversor_adc
    import conversor_adc_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clock_enable,
    input  logic                 spi_miso,
    output logic                 spi_sck,
    output logic                 ad_conv,
    output logic [DATA_BITS-1:0] canal_a,
    output logic [DATA_BITS-1:0] canal_b,
    output logic [DAC_BITS-1:0]  muestra_dac,
    output logic                 dato_valido,
    output logic                 ocupado
);

    localparam logic [5:0] A_LO     = 6'(CH_A_FIRST);
    localparam logic [5:0] A_HI     = 6'(CH_A_FIRST + DATA_BITS - 1);
    localparam logic [5:0] B_LO     = 6'(CH_B_FIRST);
    localparam logic [5:0] B_HI     = 6'(CH_B_FIRST + DATA_BITS - 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    estado_t              state_q, state_d;
    logic [5:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sr_a_q, sr_a_d, sr_b_q, sr_b_d;
    logic [DATA_BITS-1:0] canal_a_q, canal_a_d, canal_b_q, canal_b_d;
    logic                 ad_conv_q, ad_conv_d;
    logic                 dato_valido_q, dato_valido_d;
    logic                 ocupado_q, ocupado_d;
    logic                 gen_run, gen_sck_en, rise_tick, period_end;

    assign gen_run    = (state_q == ST_CONV) || (state_q == ST_SHIFT);
    assign gen_sck_en = (state_q == ST_SHIFT);

    generador_sck #(.CLK_DIV(CLK_DIV)) u_sck (
        .clock      (clock),
        .reset      (reset),
        .run        (gen_run),
        .sck_en     (gen_sck_en),
        .sck        (spi_sck),
        .rise_tick  (rise_tick),
        .period_end (period_end)
    );

    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        sr_a_d        = sr_a_q;
        sr_b_d        = sr_b_q;
        canal_a_d     = canal_a_q;
        canal_b_d     = canal_b_q;
        ad_conv_d     = ad_conv_q;
        dato_valido_d = 1'b0;
        ocupado_d     = ocupado_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clock_enable) begin
                    state_d   = ST_CONV;
                    ad_conv_d = 1'b1;
                    ocupado_d = 1'b1;
                    bit_d     = '0;
                end
            end
            ST_CONV: begin
                if (period_end) begin
                    state_d   = ST_SHIFT;
                    ad_conv_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                // MISO is taken on the same edge that drives SCK high.
                if (rise_tick) begin
                    if (bit_q >= A_LO && bit_q <= A_HI)
                        sr_a_d = {sr_a_q[DATA_BITS-2:0], spi_miso};
                    if (bit_q >= B_LO && bit_q <= B_HI)
                        sr_b_d = {sr_b_q[DATA_BITS-2:0], spi_miso};
                end
                if (period_end) begin
                    if (bit_q == LAST_BIT) begin
                        state_d       = ST_DONE;
                        canal_a_d     = sr_a_q;
                        canal_b_d     = sr_b_q;
                        dato_valido_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                ocupado_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_q         <= '0;
            sr_a_q        <= '0;
            sr_b_q        <= '0;
            canal_a_q     <= '0;
            canal_b_q     <= '0;
            ad_conv_q     <= 1'b0;
            dato_valido_q <= 1'b0;
            ocupado_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            sr_a_q        <= sr_a_d;
            sr_b_q        <= sr_b_d;
            canal_a_q     <= canal_a_d;
            canal_b_q     <= canal_b_d;
            ad_conv_q     <= ad_conv_d;
            dato_valido_q <= dato_valido_d;
            ocupado_q     <= ocupado_d;
        end
    end

    assign ad_conv     = ad_conv_q;
    assign canal_a     = canal_a_q;
    assign canal_b     = canal_b_q;
    assign muestra_dac = canal_a_q[DATA_BITS-1 -: DAC_BITS];
    assign dato_valido = dato_valido_q;
    assign ocupado     = ocupado_q;

endmodule
